pic_irq_dispatcher: RTL
=======================

// Module: pic_irq_dispatcher
// PURPOSE
//  AXI-lite master that configures and services a pic_axi_lite instance. After reset it
//  writes the enable mask into the PIC. Each time the PIC 'interrupt' output rises, it
//  reads the pending register, picks the lowest-index pending source and hands its ID
//  to a consumer over a valid/ready handshake. After the consumer signals end-of-interrupt
//  (EOI), it clears that source in the PIC with a W1C write.
// PARAMETERS
//  NUM_IRQ     16       number of PIC sources (1..32); ID width IDW=$clog2(NUM_IRQ), min 1
//  BASE_ADDR   32'h0    PIC base address on the AXI-lite bus
//  OFF_ENABLE  32'h04   offset of the enable register (R/W)
//  OFF_PENDING 32'h08   offset of the pending register (RO)
//  OFF_CLEAR   32'h0C   offset of the clear register (W1C)
// PORTS
//  aclk           in   1        clock
//  aresetn        in   1        asynchronous active-low reset
//  m_axi_awaddr   out  32       write address
//  m_axi_awvalid  out  1
//  m_axi_awready  in   1
//  m_axi_wdata    out  32       write data
//  m_axi_wvalid   out  1
//  m_axi_wready   in   1
//  m_axi_bresp    in   2
//  m_axi_bvalid   in   1
//  m_axi_bready   out  1
//  m_axi_araddr   out  32       read address
//  m_axi_arvalid  out  1
//  m_axi_arready  in   1
//  m_axi_rdata    in   32
//  m_axi_rresp    in   2
//  m_axi_rvalid   in   1
//  m_axi_rready   out  1
//  interrupt      in   1        PIC interrupt output (level)
//  cfg_enable     in   NUM_IRQ  enable mask; written at boot and on cfg_update
//  cfg_update     in   1        1-cycle pulse: rewrite ENABLE (pended until IDLE)
//  vec_valid      out  1        dispatched source ID valid
//  vec_id         out  IDW      dispatched source ID
//  vec_ready      in   1        consumer accepts vec_id
//  eoi            in   1        1-cycle pulse: consumer finished the accepted vector
//  busy           out  1        high in any state other than IDLE
//  err            out  1        sticky: set by any bresp/rresp != 2'b00; cleared only by reset
// BEHAVIOUR
//  Reset: all valid outputs low; bready/rready low; busy low; err low; vec_id 0;
//   addresses and data 0; FSM enters CFG_AW one cycle after reset release.
//   Reset asserted mid-transaction drops every valid immediately.
//  States:
//   CFG_AW   ENABLE write at BASE_ADDR+OFF_ENABLE; data = zero-extended cfg_enable
//   CFG_B    -> IDLE
//   IDLE     -> CFG_AW if an update is pended (update has priority over interrupt);
//            else -> RD_AR if interrupt==1
//   RD_AR    araddr = BASE_ADDR+OFF_PENDING
//   RD_R     rready=1; on rvalid: pend = rdata[NUM_IRQ-1:0] & cfg_enable;
//            pend==0 or rresp!=0 -> IDLE (spurious); else -> DISPATCH
//   DISPATCH vec_valid=1 with vec_id = lowest set bit of pend; vec_id stable while
//            vec_valid is high; on vec_ready -> WAIT_EOI
//   WAIT_EOI wait for eoi -> CLR_AW
//   CLR_AW   W1C write to BASE_ADDR+OFF_CLEAR; wdata = 32'b1 << vec_id
//   CLR_B    -> IDLE
//  Write channels (CFG_AW, CLR_AW):
//   - awvalid and wvalid rise in the same cycle; each drops independently after its own
//     ready is sampled high; either order, or both together, is legal.
//   - Advance to the matching *_B state once both handshakes have completed.
//  B states: bready=1; advance on bvalid.
//  Read: arvalid held until arready; rready=1 only in RD_R.
//  Dispatch rule: one vector in flight at a time. Remaining pending sources are
//   rediscovered by a fresh read once interrupt is still high back in IDLE.
//  Latency: IDLE with interrupt=1 -> arvalid in the next cycle. With zero-wait slave,
//   rvalid in cycle N -> vec_valid in cycle N+1.
//  Edge cases:
//   - cfg_update arriving outside IDLE is latched (one-deep) and served on the next IDLE.
//   - eoi outside WAIT_EOI is ignored.
//   - interrupt dropping after RD_AR does not abort the sequence.
// TESTING
//  1 Release reset, 0-wait slave, cfg_enable=16'hFFFF -> one write 0x04/0x0000FFFF, then idle.
//  2 PENDING=0x0020 -> vec_id=5; after eoi, write 0x0C/0x00000020; busy low after bvalid.
//  3 PENDING=0x0208 -> vec_id=3, clear 0x8; interrupt still high, PENDING=0x0200 ->
//    vec_id=9, clear 0x200.
//  4 PENDING read returns 0, or enable masks it -> no vec_valid, return to IDLE;
//    rresp=2'b10 -> err=1, no dispatch.
//  5 awready 3 cycles before wready (and the reverse) -> awvalid/wvalid drop individually;
//    exactly one B handshake per write.
//  6 aresetn low while in DISPATCH -> vec_valid=0 at once; after release, ENABLE is rewritten.
//    cfg_update during WAIT_EOI -> ENABLE written after the clear completes.

Source files
------------

// File: rtl/pic_irq_dispatcher.sv
// ---------------------------------------------------------------------------
// pic_irq_dispatcher
//
// AXI-lite master that boots and services a pic_axi_lite instance. After reset
// it writes the enable mask into the PIC. Whenever the PIC interrupt line is
// high while idle, it reads the pending register. It then picks the lowest-index
// pending (and enabled) source and offers that ID to a consumer over a
// valid/ready handshake. After the consumer's end-of-interrupt pulse, it clears
// the source with a write-1-to-clear access. Only one vector is in flight at a
// time. Any sources still pending are found by a fresh read on the next pass
// through IDLE.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   m_axi_aw* / m_axi_w*   write address / write data channels (master side)
//   m_axi_b*               write response channel
//   m_axi_ar* / m_axi_r*   read address / read data channels
//   interrupt              PIC interrupt output (level)
//   cfg_enable             enable mask written at boot and on cfg_update
//   cfg_update             1-cycle pulse requesting an ENABLE rewrite
//   vec_valid/vec_id       dispatched source ID, held stable until vec_ready
//   vec_ready              consumer accepts vec_id
//   eoi                    1-cycle pulse: consumer finished the accepted vector
//   busy                   high in every state except IDLE
//   err                    sticky error: any non-OKAY bresp/rresp
// ---------------------------------------------------------------------------
module pic_irq_dispatcher #(
    parameter int          NUM_IRQ     = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] OFF_ENABLE  = 32'h0000_0004,
    parameter logic [31:0] OFF_PENDING = 32'h0000_0008,
    parameter logic [31:0] OFF_CLEAR   = 32'h0000_000C,
    localparam int         IDW         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               aclk,
    input  logic               aresetn,

    output logic [31:0]        m_axi_awaddr,
    output logic               m_axi_awvalid,
    input  logic               m_axi_awready,
    output logic [31:0]        m_axi_wdata,
    output logic               m_axi_wvalid,
    input  logic               m_axi_wready,
    input  logic [1:0]         m_axi_bresp,
    input  logic               m_axi_bvalid,
    output logic               m_axi_bready,
    output logic [31:0]        m_axi_araddr,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,
    input  logic [31:0]        m_axi_rdata,
    input  logic [1:0]         m_axi_rresp,
    input  logic               m_axi_rvalid,
    output logic               m_axi_rready,

    input  logic               interrupt,
    input  logic [NUM_IRQ-1:0] cfg_enable,
    input  logic               cfg_update,
    output logic               vec_valid,
    output logic [IDW-1:0]     vec_id,
    input  logic               vec_ready,
    input  logic               eoi,
    output logic               busy,
    output logic               err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_AW,
        S_CFG_B,
        S_RD_AR,
        S_RD_R,
        S_DISPATCH,
        S_WAIT_EOI,
        S_CLR_AW,
        S_CLR_B
    } state_t;

    localparam logic [31:0] ADDR_ENABLE  = BASE_ADDR + OFF_ENABLE;
    localparam logic [31:0] ADDR_PENDING = BASE_ADDR + OFF_PENDING;
    localparam logic [31:0] ADDR_CLEAR   = BASE_ADDR + OFF_CLEAR;

    state_t             state_q, state_d;
    logic               upd_pend_q;
    logic               aw_done_q, w_done_q;
    logic [31:0]        wdata_q;
    logic [IDW-1:0]     vec_id_q;
    logic               err_q;

    logic               wr_phase;
    logic               aw_ok, w_ok;
    logic [NUM_IRQ-1:0] pend;
    logic [IDW-1:0]     first_id;
    logic               rd_accept;

    // Upper read-data bits beyond NUM_IRQ carry no meaning for this PIC.
    logic               unused_rdata;
    assign unused_rdata = &{1'b0, m_axi_rdata};

    // Pending sources qualified by the current enable mask, and the lowest set
    // bit among them (priority to the smallest index).
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        pend     = m_axi_rdata[NUM_IRQ-1:0] & cfg_enable;
        first_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) first_id = IDW'(i);
        end
    end

    // A read response opens a dispatch only if it is OKAY and something is
    // actually pending; anything else is treated as spurious.
    assign rd_accept = (pend != '0) && (m_axi_rresp == 2'b00);

    assign wr_phase = (state_q == S_CFG_AW) || (state_q == S_CLR_AW);
    // Each write channel is finished once its own handshake has happened,
    // either in an earlier cycle (done flag) or in this one.
    assign aw_ok    = aw_done_q || (m_axi_awvalid && m_axi_awready);
    assign w_ok     = w_done_q  || (m_axi_wvalid  && m_axi_wready);

    // Next state and all bus outputs decode from the registered state, so an
    // asynchronous reset drops every valid immediately.
    always_comb begin
        state_d       = state_q;
        m_axi_awaddr  = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        vec_valid     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A pended (or arriving) update wins over an interrupt.
                if (upd_pend_q || cfg_update) state_d = S_CFG_AW;
                else if (interrupt)           state_d = S_RD_AR;
            end
            S_CFG_AW: begin
                m_axi_awaddr  = ADDR_ENABLE;
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                if (aw_ok && w_ok) state_d = S_CFG_B;
            end
            S_CFG_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_d = S_IDLE;
            end
            S_RD_AR: begin
                m_axi_araddr  = ADDR_PENDING;
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = S_RD_R;
            end
            S_RD_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_d = rd_accept ? S_DISPATCH : S_IDLE;
            end
            S_DISPATCH: begin
                vec_valid = 1'b1;
                if (vec_ready) state_d = S_WAIT_EOI;
            end
            S_WAIT_EOI: begin
                if (eoi) state_d = S_CLR_AW;
            end
            S_CLR_AW: begin
                m_axi_awaddr  = ADDR_CLEAR;
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                if (aw_ok && w_ok) state_d = S_CLR_B;
            end
            S_CLR_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_axi_wdata = wdata_q;
    assign vec_id      = vec_id_q;
    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            // Reset leaves a boot update pended, so the first cycle after
            // release moves IDLE -> CFG_AW and writes the enable mask.
            upd_pend_q <= 1'b1;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wdata_q    <= '0;
            vec_id_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            // One-deep update latch; taking the update out of IDLE consumes it.
            if ((state_q == S_IDLE) && (state_d == S_CFG_AW)) upd_pend_q <= 1'b0;
            else if (cfg_update)                              upd_pend_q <= 1'b1;

            if (wr_phase && !(aw_ok && w_ok)) begin
                aw_done_q <= aw_ok;
                w_done_q  <= w_ok;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end

            // Write data is captured on entry to a write state and held
            // stable for the whole write.
            if ((state_q == S_IDLE) && (state_d == S_CFG_AW))
                wdata_q <= 32'(cfg_enable);
            else if ((state_q == S_WAIT_EOI) && eoi)
                wdata_q <= 32'd1 << vec_id_q;

            if ((state_q == S_RD_R) && m_axi_rvalid && rd_accept)
                vec_id_q <= first_id;

            if ((m_axi_bvalid && m_axi_bready && (m_axi_bresp != 2'b00)) ||
                (m_axi_rvalid && m_axi_rready && (m_axi_rresp != 2'b00)))
                err_q <= 1'b1;
        end
    end

endmodule
